branch_predict_table: RTL and testbench
=======================================

Name: branch_predict_table

Overview:
- Direct-mapped branch history/target table that consumes branch-resolution updates from the execute stage and produces registered predictions for the fetch stage.
- Each entry holds valid, tag, target and a 2-bit saturating counter.
- Updates are registered for one cycle, then written; a bypass keeps back-to-back lookups coherent.
- Sits between the instruction-fetch PC generator (lookup side) and the execute/delayed-exec branch resolution (update side).

Parameters:
- ENTRIES, 64, number of table entries; power of two, 4..1024.
- IDX_W, $clog2(ENTRIES), index width; index = pc[IDX_W+1:2].
- TAG_W, 30-IDX_W, tag width; tag = pc[31:IDX_W+2].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  clear every entry's valid bit.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  32  fetch PC to predict.
- predict_valid  out  1  registered; entry hit for the previous cycle's lookup.
- predict_taken  out  1  registered; predicted direction, equal to counter[1].
- predict_target  out  32  registered; stored target.
- predict_counter  out  2  registered; stored counter, echoed back later on upd_counter.
- upd_valid  in  1  resolved control-flow instruction.
- upd_pc  in  32  PC of resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target.
- upd_counter  in  2  counter value the prediction was made with.
- upd_cond  in  1  1 = conditional branch, 0 = unconditional jump.

Behaviour:
- Reset (rst_n low, async): all entry valid bits = 0; update register U1 empty; predict_valid = 0; predict_taken = 0; predict_target = 0; predict_counter = 2'b01.
- Lookup latency is 1 cycle.
  - At edge with lookup_valid=1, outputs load from entry[lookup_pc index].
  - predict_valid = entry.valid & (entry.tag == lookup tag).
  - On a miss: predict_valid=0, predict_taken=0, predict_counter=2'b01, predict_target = lookup_pc+8.
- lookup_valid=0 at an edge: predict_valid=0 next cycle; the other outputs hold their values.
- Update pipeline:
  - Edge N: upd_* captured into U1.
  - Edge N+1: U1 written to the table, and U1 loads the next update if upd_valid. One update per cycle is sustained.
- Write rules at edge N+1, with E = entry[U1 index]:
  - Hit (E.valid & tag match), conditional:
    - counter = sat(upd_counter + 1) if taken, else sat(upd_counter - 1).
    - Saturation: 11 + 1 = 11; 00 - 1 = 00.
    - Target is overwritten only when taken.
  - Hit, unconditional: counter = 11, target overwritten.
  - Miss and taken: allocate/replace. valid=1, tag, target; counter = 10 if cond, 11 if uncond.
  - Miss and not taken: no write.
- Bypass: if a lookup is sampled at the same edge U1 writes the same index, the prediction reflects the post-write entry value.
- Flush:
  - At the edge where flush=1, all valid bits clear.
  - U1 content is discarded without writing; upd_valid sampled that edge is dropped.
  - A lookup sampled that edge returns predict_valid=0.
  - flush has priority over every write.
- Updates are never back-pressured; the producer may assert upd_valid every cycle.
- Aliasing: differing tags with the same index behave as a miss; no multi-way storage.

Test Plan:
- Reset, then lookup_pc=0x8000_0010 -> predict_valid=0, predict_counter=01, predict_target=0x8000_0018.
- upd pc=0x8000_0010, taken=1, target=0x8000_0100, cond=1, counter=01. Lookup same pc 2 cycles later -> predict_valid=1, predict_taken=1, counter=10, target=0x8000_0100.
- Repeated hits at pc 0x8000_0010, each update feeding back the returned counter:
  - Three taken updates -> counter 11 (saturates).
  - Then four not-taken updates -> 10, 01, 00, 00; predict_taken=0; target unchanged.
- Alias: pc 0x8000_0010 resident; upd pc=0x8000_0110 (same index at ENTRIES=64), taken=1, uncond -> that pc hits with counter 11; 0x8000_0010 now misses. A not-taken update to a third aliasing pc makes no change.
- Bypass: upd at cycle 0; lookup of the same pc at cycle 1 (U1 writes that edge) -> the cycle-2 prediction shows the new entry.
- Flush with a pending U1 and upd_valid=1 -> all later lookups miss; neither update is written; async rst_n pulse mid-stream likewise clears all valid bits and outputs.

Source files
------------

// File: rtl/branch_predict_table.sv
// Direct-mapped branch target/direction table: registered lookups for fetch,
// one-cycle-registered updates from execute, with write-to-lookup bypass.
module branch_predict_table #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        predict_valid,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  output logic [1:0]  predict_counter,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_counter,
  input  logic        upd_cond
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_mem     [ENTRIES];
  logic [31:0]        target_mem  [ENTRIES];
  logic [1:0]         counter_mem [ENTRIES];

  logic               u1_valid_q, u1_valid_d;
  logic [IDX_W-1:0]   u1_idx_q, u1_idx_d;
  logic [TAG_W-1:0]   u1_tag_q, u1_tag_d;
  logic               u1_taken_q, u1_taken_d;
  logic [31:0]        u1_target_q, u1_target_d;
  logic [1:0]         u1_counter_q, u1_counter_d;
  logic               u1_cond_q, u1_cond_d;

  logic               pv_q, pv_d;
  logic               ptaken_q, ptaken_d;
  logic [31:0]        ptarget_q, ptarget_d;
  logic [1:0]         pcounter_q, pcounter_d;

  logic               u1_hit;
  logic               wr_en;
  logic [31:0]        wr_target;
  logic [1:0]         wr_counter;

  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               e_valid;
  logic [TAG_W-1:0]   e_tag;
  logic [31:0]        e_target;
  logic [1:0]         e_counter;
  logic               lk_hit;

  logic               unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];

  // Update capture stage; a flush drops whatever arrives on the same edge.
  always_comb begin
    u1_valid_d   = upd_valid & ~flush;
    u1_idx_d     = u1_idx_q;
    u1_tag_d     = u1_tag_q;
    u1_taken_d   = u1_taken_q;
    u1_target_d  = u1_target_q;
    u1_counter_d = u1_counter_q;
    u1_cond_d    = u1_cond_q;
    if (upd_valid) begin
      u1_idx_d     = upd_pc[IDX_W+1:2];
      u1_tag_d     = upd_pc[31:IDX_W+2];
      u1_taken_d   = upd_taken;
      u1_target_d  = upd_target;
      u1_counter_d = upd_counter;
      u1_cond_d    = upd_cond;
    end
  end

  // Table write decision for the update held in U1.
  always_comb begin
    u1_hit     = valid_q[u1_idx_q] && (tag_mem[u1_idx_q] == u1_tag_q);
    wr_en      = 1'b0;
    wr_target  = target_mem[u1_idx_q];
    wr_counter = counter_mem[u1_idx_q];
    if (u1_valid_q && !flush) begin
      if (u1_hit) begin
        wr_en = 1'b1;
        if (u1_cond_q) begin
          if (u1_taken_q) begin
            wr_counter = (u1_counter_q == 2'b11) ? 2'b11 : u1_counter_q + 2'd1;
            wr_target  = u1_target_q;
          end else begin
            wr_counter = (u1_counter_q == 2'b00) ? 2'b00 : u1_counter_q - 2'd1;
          end
        end else begin
          wr_counter = 2'b11;
          wr_target  = u1_target_q;
        end
      end else if (u1_taken_q) begin
        wr_en      = 1'b1;
        wr_target  = u1_target_q;
        wr_counter = u1_cond_q ? 2'b10 : 2'b11;
      end
    end
    valid_d = flush ? '0 : valid_q;
    if (wr_en) valid_d[u1_idx_q] = 1'b1;
  end

  // Lookup sees the entry as it will be after this edge's write.
  always_comb begin
    e_valid   = valid_q[lk_idx];
    e_tag     = tag_mem[lk_idx];
    e_target  = target_mem[lk_idx];
    e_counter = counter_mem[lk_idx];
    if (wr_en && (u1_idx_q == lk_idx)) begin
      e_valid   = 1'b1;
      e_tag     = u1_tag_q;
      e_target  = wr_target;
      e_counter = wr_counter;
    end
    lk_hit = e_valid && (e_tag == lk_tag) && !flush;

    pv_d       = 1'b0;
    ptaken_d   = ptaken_q;
    ptarget_d  = ptarget_q;
    pcounter_d = pcounter_q;
    if (lookup_valid) begin
      pv_d = lk_hit;
      if (lk_hit) begin
        ptaken_d   = e_counter[1];
        ptarget_d  = e_target;
        pcounter_d = e_counter;
      end else begin
        ptaken_d   = 1'b0;
        ptarget_d  = lookup_pc + 32'd8;
        pcounter_d = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      u1_valid_q   <= 1'b0;
      u1_idx_q     <= '0;
      u1_tag_q     <= '0;
      u1_taken_q   <= 1'b0;
      u1_target_q  <= '0;
      u1_counter_q <= 2'b01;
      u1_cond_q    <= 1'b0;
      pv_q         <= 1'b0;
      ptaken_q     <= 1'b0;
      ptarget_q    <= '0;
      pcounter_q   <= 2'b01;
    end else begin
      valid_q      <= valid_d;
      u1_valid_q   <= u1_valid_d;
      u1_idx_q     <= u1_idx_d;
      u1_tag_q     <= u1_tag_d;
      u1_taken_q   <= u1_taken_d;
      u1_target_q  <= u1_target_d;
      u1_counter_q <= u1_counter_d;
      u1_cond_q    <= u1_cond_d;
      pv_q         <= pv_d;
      ptaken_q     <= ptaken_d;
      ptarget_q    <= ptarget_d;
      pcounter_q   <= pcounter_d;
    end
  end

  // Payload storage needs no reset; valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[u1_idx_q]     <= u1_tag_q;
      target_mem[u1_idx_q]  <= wr_target;
      counter_mem[u1_idx_q] <= wr_counter;
    end
  end

  assign predict_valid   = pv_q;
  assign predict_taken   = ptaken_q;
  assign predict_target  = ptarget_q;
  assign predict_counter = pcounter_q;

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed, table-driven bench for branch_predict_table with hand-written
// reset sequences.
module tb_branch_predict_table;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict_valid;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic [1:0]  predict_counter;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [1:0]  upd_counter;
  logic        upd_cond;

  int n_chk;
  int n_fail;

  branch_predict_table dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(predict_valid), .predict_taken(predict_taken),
    .predict_target(predict_target), .predict_counter(predict_counter),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_counter(upd_counter), .upd_cond(upd_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        lv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [1:0]  uctr;
    logic        ucond;
    logic        fl;
    logic        full;
    logic        epv;
    logic        etk;
    logic [31:0] etgt;
    logic [1:0]  ectr;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t idle();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t lk(input logic [31:0] pc, input logic pv, input logic tk,
                              input logic [31:0] tgt, input logic [1:0] ctr);
    vec_t v;
    v = '0;
    v.lv = 1'b1; v.lpc = pc; v.full = 1'b1;
    v.epv = pv; v.etk = tk; v.etgt = tgt; v.ectr = ctr;
    return v;
  endfunction

  function automatic vec_t up(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                              input logic [1:0] ctr, input logic cond);
    vec_t v;
    v = '0;
    v.uv = 1'b1; v.upc = pc; v.ut = t; v.utgt = tgt; v.uctr = ctr; v.ucond = cond;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pv, input logic tk,
                         input logic [31:0] tgt, input logic [1:0] ctr);
    chk({tag, ".predict_valid"}, {31'd0, predict_valid}, {31'd0, pv});
    chk({tag, ".predict_taken"}, {31'd0, predict_taken}, {31'd0, tk});
    chk({tag, ".predict_target"}, predict_target, tgt);
    chk({tag, ".predict_counter"}, {30'd0, predict_counter}, {30'd0, ctr});
  endtask

  task automatic apply(input vec_t v);
    lookup_valid = v.lv; lookup_pc = v.lpc;
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut;
    upd_target = v.utgt; upd_counter = v.uctr; upd_cond = v.ucond;
    flush = v.fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;

    vecs[0]  = lk(32'h8000_0010, 0, 0, 32'h8000_0018, 2'b01);
    vecs[1]  = up(32'h8000_0010, 1, 32'h8000_0100, 2'b01, 1);
    vecs[1].full = 1'b1; vecs[1].etgt = 32'h8000_0018; vecs[1].ectr = 2'b01;
    vecs[2]  = idle();
    vecs[2].full = 1'b1; vecs[2].etgt = 32'h8000_0018; vecs[2].ectr = 2'b01;
    vecs[3]  = lk(32'h8000_0010, 1, 1, 32'h8000_0100, 2'b10);
    vecs[4]  = up(32'h8000_0010, 1, 32'h8000_0100, 2'b10, 1);
    vecs[5]  = lk(32'h8000_0010, 1, 1, 32'h8000_0100, 2'b11);
    vecs[6]  = up(32'h8000_0010, 1, 32'h8000_0100, 2'b11, 1);
    vecs[7]  = lk(32'h8000_0010, 1, 1, 32'h8000_0100, 2'b11);
    vecs[8]  = up(32'h8000_0010, 1, 32'h8000_0100, 2'b11, 1);
    vecs[9]  = lk(32'h8000_0010, 1, 1, 32'h8000_0100, 2'b11);
    vecs[10] = up(32'h8000_0010, 0, 32'h8000_0200, 2'b11, 1);
    vecs[11] = lk(32'h8000_0010, 1, 1, 32'h8000_0100, 2'b10);
    vecs[12] = up(32'h8000_0010, 0, 32'h8000_0200, 2'b10, 1);
    vecs[13] = lk(32'h8000_0010, 1, 0, 32'h8000_0100, 2'b01);
    vecs[14] = up(32'h8000_0010, 0, 32'h8000_0200, 2'b01, 1);
    vecs[15] = lk(32'h8000_0010, 1, 0, 32'h8000_0100, 2'b00);
    vecs[16] = up(32'h8000_0010, 0, 32'h8000_0200, 2'b00, 1);
    vecs[17] = lk(32'h8000_0010, 1, 0, 32'h8000_0100, 2'b00);
    vecs[18] = up(32'h8000_0110, 1, 32'h8000_0400, 2'b01, 0);
    vecs[19] = idle();
    vecs[20] = lk(32'h8000_0110, 1, 1, 32'h8000_0400, 2'b11);
    vecs[21] = lk(32'h8000_0010, 0, 0, 32'h8000_0018, 2'b01);
    vecs[22] = up(32'h8000_0210, 0, 32'h8000_0500, 2'b01, 1);
    vecs[23] = idle();
    vecs[24] = lk(32'h8000_0110, 1, 1, 32'h8000_0400, 2'b11);
    vecs[25] = lk(32'h8000_0210, 0, 0, 32'h8000_0218, 2'b01);
    vecs[26] = up(32'h8000_0020, 1, 32'h8000_0800, 2'b01, 1);
    vecs[27] = up(32'h8000_0030, 1, 32'h8000_0900, 2'b01, 0);
    vecs[27].fl = 1'b1; vecs[27].lv = 1'b1; vecs[27].lpc = 32'h8000_0110;
    vecs[27].full = 1'b1; vecs[27].etgt = 32'h8000_0118; vecs[27].ectr = 2'b01;
    vecs[28] = idle();
    vecs[29] = lk(32'h8000_0020, 0, 0, 32'h8000_0028, 2'b01);
    vecs[30] = lk(32'h8000_0030, 0, 0, 32'h8000_0038, 2'b01);
    vecs[31] = lk(32'h8000_0110, 0, 0, 32'h8000_0118, 2'b01);

    rst_n = 1'b0;
    apply(idle());
    apply(idle());
    #4 rst_n = 1'b1;
    chk_out("reset", 0, 0, 32'h0, 2'b01);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      if (vecs[i].full)
        chk_out($sformatf("vec%0d", i), vecs[i].epv, vecs[i].etk, vecs[i].etgt, vecs[i].ectr);
      else
        chk($sformatf("vec%0d.predict_valid", i), {31'd0, predict_valid}, {31'd0, vecs[i].epv});
    end

    apply(up(32'h8000_0040, 1, 32'h8000_0a00, 2'b01, 1));
    apply(idle());
    apply(lk(32'h8000_0040, 0, 0, 0, 2'b00));
    chk_out("pre_rst_hit", 1, 1, 32'h8000_0a00, 2'b10);
    apply(up(32'h8000_0050, 1, 32'h8000_0b00, 2'b01, 0));
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 0, 0, 32'h0, 2'b01);
    #1 rst_n = 1'b1;
    apply(idle());
    chk_out("rst_idle", 0, 0, 32'h0, 2'b01);
    apply(lk(32'h8000_0040, 0, 0, 0, 2'b00));
    chk_out("post_rst_40", 0, 0, 32'h8000_0048, 2'b01);
    apply(lk(32'h8000_0050, 0, 0, 0, 2'b00));
    chk_out("post_rst_50", 0, 0, 32'h8000_0058, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
